zx_ps2_keyboard: RTL and testbench

PS/2 keyboard receiver and ZX Spectrum key-matrix emulator feeding the ULA's port #FE read path. Samples the PS/2 clock/data lines on clk28 and decodes set-2 scan codes, including make/break and E0 prefixes. Maintains an 8×5 Spectrum matrix and returns the active-low column bits selected by CPU address lines A15..A8. Also drives the magic (NMI) and reset requests that the ULA consumes.

---
 rtl/zx_ps2_keyboard.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_zx_ps2_keyboard.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_ps2_keyboard.sv
// PS/2 set-2 keyboard receiver driving an emulated ZX Spectrum 8x5 key matrix.
// Define ZX_PS2_CURSOR_EN to decode E0-prefixed arrow keys as CS+5/6/7/8.
`timescale 1ns/1ps
module zx_ps2_keyboard #(
  parameter int TIMEOUT_W  = 17,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] a_hi,
  output logic [4:0] kd,
  output logic       n_magic,
  output logic       n_kbrst,
  output logic       frame_err,
  output logic [1:0] dbg_rx_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int FCW = $clog2(FILTER_LEN) + 1;
`ifdef ZX_PS2_CURSOR_EN
  localparam int NSRC = 5;
`else
  localparam int NSRC = 1;
`endif

  logic                 r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic                 r_clk_filt;
  logic [FCW-1:0]       r_filt_cnt;
  logic                 w_flip, w_strobe, w_dat;

  logic [1:0]           r_state;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_parity;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic                 r_byte_vld;
  logic [7:0]           r_byte;
  logic                 r_frame_err;

  logic                 r_ext, r_brk;
  logic [7:0][4:0]      r_mat;
  logic [NSRC-1:0]      r_shift_src;
  logic                 r_magic_n, r_kbrst_n;
  logic [4:0]           r_kd;

  logic [6:0]           w_map;
  logic                 w_map_hit;
  logic [2:0]           w_map_row, w_map_col;
  logic [7:0][4:0]      w_rows;
  logic [4:0]           w_kd;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_dat;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign w_flip   = (r_clk_sync != r_clk_filt) && (r_filt_cnt == FCW'(FILTER_LEN - 1));
  assign w_strobe = w_flip && r_clk_filt;
  assign w_dat    = r_dat_sync;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_sync == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_flip) begin
      r_clk_filt <= r_clk_sync;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tmo       <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_strobe) begin
        r_tmo <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!w_dat) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_parity <= w_dat;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            if (w_dat && (^{r_shift, r_parity})) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state == ST_IDLE) begin
        r_tmo <= '0;
      end else if (&r_tmo) begin
        r_frame_err <= 1'b1;
        r_state     <= ST_IDLE;
        r_tmo       <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  // Set-2 code -> {hit, row, column} in Spectrum matrix order.
  always_comb begin
    w_map = 7'd0;
    case (r_byte)
      8'h12: w_map = {1'b1, 3'd0, 3'd0};
      8'h1A: w_map = {1'b1, 3'd0, 3'd1};
      8'h22: w_map = {1'b1, 3'd0, 3'd2};
      8'h21: w_map = {1'b1, 3'd0, 3'd3};
      8'h2A: w_map = {1'b1, 3'd0, 3'd4};
      8'h1C: w_map = {1'b1, 3'd1, 3'd0};
      8'h1B: w_map = {1'b1, 3'd1, 3'd1};
      8'h23: w_map = {1'b1, 3'd1, 3'd2};
      8'h2B: w_map = {1'b1, 3'd1, 3'd3};
      8'h34: w_map = {1'b1, 3'd1, 3'd4};
      8'h15: w_map = {1'b1, 3'd2, 3'd0};
      8'h1D: w_map = {1'b1, 3'd2, 3'd1};
      8'h24: w_map = {1'b1, 3'd2, 3'd2};
      8'h2D: w_map = {1'b1, 3'd2, 3'd3};
      8'h2C: w_map = {1'b1, 3'd2, 3'd4};
      8'h16: w_map = {1'b1, 3'd3, 3'd0};
      8'h1E: w_map = {1'b1, 3'd3, 3'd1};
      8'h26: w_map = {1'b1, 3'd3, 3'd2};
      8'h25: w_map = {1'b1, 3'd3, 3'd3};
      8'h2E: w_map = {1'b1, 3'd3, 3'd4};
      8'h45: w_map = {1'b1, 3'd4, 3'd0};
      8'h46: w_map = {1'b1, 3'd4, 3'd1};
      8'h3E: w_map = {1'b1, 3'd4, 3'd2};
      8'h3D: w_map = {1'b1, 3'd4, 3'd3};
      8'h36: w_map = {1'b1, 3'd4, 3'd4};
      8'h4D: w_map = {1'b1, 3'd5, 3'd0};
      8'h44: w_map = {1'b1, 3'd5, 3'd1};
      8'h43: w_map = {1'b1, 3'd5, 3'd2};
      8'h3C: w_map = {1'b1, 3'd5, 3'd3};
      8'h35: w_map = {1'b1, 3'd5, 3'd4};
      8'h5A: w_map = {1'b1, 3'd6, 3'd0};
      8'h4B: w_map = {1'b1, 3'd6, 3'd1};
      8'h42: w_map = {1'b1, 3'd6, 3'd2};
      8'h3B: w_map = {1'b1, 3'd6, 3'd3};
      8'h33: w_map = {1'b1, 3'd6, 3'd4};
      8'h29: w_map = {1'b1, 3'd7, 3'd0};
      8'h59: w_map = {1'b1, 3'd7, 3'd1};
      8'h3A: w_map = {1'b1, 3'd7, 3'd2};
      8'h31: w_map = {1'b1, 3'd7, 3'd3};
      8'h32: w_map = {1'b1, 3'd7, 3'd4};
      default: w_map = 7'd0;
    endcase
  end

  assign w_map_hit = w_map[6];
  assign w_map_row = w_map[5:3];
  assign w_map_col = w_map[2:0];

`ifdef ZX_PS2_CURSOR_EN
  logic [9:0] w_arw;
  logic       w_arw_hit;
  logic [2:0] w_arw_row, w_arw_col, w_arw_src;

  // Arrow -> {hit, row, column, shift source}; source 0 belongs to Backspace.
  always_comb begin
    w_arw = 10'd0;
    case (r_byte)
      8'h6B: w_arw = {1'b1, 3'd3, 3'd4, 3'd1};
      8'h72: w_arw = {1'b1, 3'd4, 3'd4, 3'd2};
      8'h75: w_arw = {1'b1, 3'd4, 3'd3, 3'd3};
      8'h74: w_arw = {1'b1, 3'd4, 3'd2, 3'd4};
      default: w_arw = 10'd0;
    endcase
  end

  assign w_arw_hit = w_arw[9];
  assign w_arw_row = w_arw[8:6];
  assign w_arw_col = w_arw[5:3];
  assign w_arw_src = w_arw[2:0];
`endif

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_mat       <= '1;
      r_shift_src <= '0;
      r_magic_n   <= 1'b1;
      r_kbrst_n   <= 1'b1;
    end else if (r_byte_vld) begin
      if (r_byte == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_byte == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (r_byte < 8'hE1) begin
          if (!r_ext) begin
            if (r_byte == 8'h78) begin
              r_magic_n <= r_brk;
            end else if (r_byte == 8'h07) begin
              r_kbrst_n <= r_brk;
            end else if (r_byte == 8'h66) begin
              r_shift_src[0] <= ~r_brk;
              r_mat[4][0]    <= r_brk;
            end else if (w_map_hit) begin
              r_mat[w_map_row][w_map_col] <= r_brk;
            end
          end
`ifdef ZX_PS2_CURSOR_EN
          else if (w_arw_hit) begin
            r_shift_src[w_arw_src]      <= ~r_brk;
            r_mat[w_arw_row][w_arw_col] <= r_brk;
          end
`endif
        end
      end
    end
  end

  // Caps Shift seen by the CPU is LShift AND'ed with every synthetic shift source.
  always_comb begin
    w_rows       = r_mat;
    w_rows[0][0] = r_mat[0][0] & ~(|r_shift_src);
    w_kd         = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!a_hi[r]) w_kd = w_kd & w_rows[r];
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) r_kd <= 5'h1F;
    else        r_kd <= w_kd;
  end

  assign kd           = r_kd;
  assign n_magic      = r_magic_n;
  assign n_kbrst      = r_kbrst_n;
  assign frame_err    = r_frame_err;
  assign dbg_rx_state = r_state;

endmodule

// File: tb/tb_zx_ps2_keyboard.sv
// Bench for zx_ps2_keyboard: PS/2 frames in, Spectrum key reads checked
// against a key-layout model driven by the set of held scan codes.
`timescale 1ns/1ps
module tb_zx_ps2_keyboard;

  localparam int HALF = 12;

  logic       clk28 = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] a_hi;
  logic [4:0] kd;
  logic       n_magic;
  logic       n_kbrst;
  logic       frame_err;
  logic [1:0] dbg_rx_state;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;

  bit    held [256];
  bit    held_ext [256];
  string layout [8];

  zx_ps2_keyboard #(.TIMEOUT_W(10), .FILTER_LEN(8)) dut (
    .clk28(clk28), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .a_hi(a_hi), .kd(kd), .n_magic(n_magic), .n_kbrst(n_kbrst),
    .frame_err(frame_err), .dbg_rx_state(dbg_rx_state)
  );

  always #18 clk28 = ~clk28;

  always @(negedge clk28) if (frame_err === 1'b1) ferr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic byte code_char(input logic [7:0] c);
    case (c)
      8'h1C: return "A"; 8'h32: return "B"; 8'h21: return "C"; 8'h23: return "D";
      8'h24: return "E"; 8'h2B: return "F"; 8'h34: return "G"; 8'h33: return "H";
      8'h43: return "I"; 8'h3B: return "J"; 8'h42: return "K"; 8'h4B: return "L";
      8'h3A: return "M"; 8'h31: return "N"; 8'h44: return "O"; 8'h4D: return "P";
      8'h15: return "Q"; 8'h2D: return "R"; 8'h1B: return "S"; 8'h2C: return "T";
      8'h3C: return "U"; 8'h2A: return "V"; 8'h1D: return "W"; 8'h22: return "X";
      8'h35: return "Y"; 8'h1A: return "Z";
      8'h16: return "1"; 8'h1E: return "2"; 8'h26: return "3"; 8'h25: return "4";
      8'h2E: return "5"; 8'h36: return "6"; 8'h3D: return "7"; 8'h3E: return "8";
      8'h46: return "9"; 8'h45: return "0";
      8'h12: return "^"; 8'h59: return "$"; 8'h5A: return "#"; 8'h29: return " ";
      default: return 0;
    endcase
  endfunction

  function automatic byte arrow_char(input logic [7:0] c);
    case (c)
      8'h6B: return "5"; 8'h72: return "6"; 8'h75: return "7"; 8'h74: return "8";
      default: return 0;
    endcase
  endfunction

  function automatic bit key_down(input byte ch);
    for (int c = 0; c < 256; c++) begin
      if (held[c]) begin
        if (code_char(8'(c)) == ch) return 1'b1;
        if (c == 8'h66 && (ch == "^" || ch == "0")) return 1'b1;
      end
`ifdef ZX_PS2_CURSOR_EN
      if (held_ext[c] && arrow_char(8'(c)) != 0 &&
          (ch == "^" || ch == arrow_char(8'(c)))) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic [4:0] model_kd(input logic [7:0] a);
    logic [4:0] k;
    string s;
    k = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!a[r]) begin
        s = layout[r];
        for (int col = 0; col < 5; col++) if (key_down(s[col])) k[col] = 1'b0;
      end
    end
    return k;
  endfunction

  // ---------------- drivers ----------------
  task automatic ps2_bit(input logic b);
    @(negedge clk28) ps2_dat = b;
    repeat (HALF) @(negedge clk28);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk28);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (24) @(negedge clk28);
  endtask

  task automatic press(input logic [7:0] c, input bit ext);
    if (ext) begin send_byte(8'hE0, 1'b0); held_ext[c] = 1'b1; end
    else held[c] = 1'b1;
    send_byte(c, 1'b0);
  endtask

  task automatic release_key(input logic [7:0] c, input bit ext);
    if (ext) begin send_byte(8'hE0, 1'b0); held_ext[c] = 1'b0; end
    else held[c] = 1'b0;
    send_byte(8'hF0, 1'b0);
    send_byte(c, 1'b0);
  endtask

  task automatic read_check(input string tag, input logic [7:0] a);
    @(negedge clk28) a_hi = a;
    @(negedge clk28);
    @(negedge clk28);
    check(tag, 32'(kd), 32'(model_kd(a)));
  endtask

  task automatic clear_model();
    for (int c = 0; c < 256; c++) begin held[c] = 1'b0; held_ext[c] = 1'b0; end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] plain_codes [40];
    logic [7:0] ext_junk [3];
    logic [7:0] unmapped [3];
    logic [7:0] code;
    int         op, f0;

    plain_codes = '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
                    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36, 8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
                    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33, 8'h29, 8'h59, 8'h3A, 8'h31, 8'h32};
    ext_junk = '{8'h1C, 8'h12, 8'h5A};
    unmapped = '{8'h05, 8'h06, 8'h0D};
    layout[0] = "^ZXCV"; layout[1] = "ASDFG"; layout[2] = "QWERT"; layout[3] = "12345";
    layout[4] = "09876"; layout[5] = "POIUY"; layout[6] = "#LKJH"; layout[7] = " $MNB";
    clear_model();

    // reset
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; a_hi = 8'h00;
    repeat (5) @(negedge clk28);
    check("reset_kd_all_rows", 32'(kd), 32'h1F);
    check("reset_n_magic", 32'(n_magic), 32'h1);
    check("reset_n_kbrst", 32'(n_kbrst), 32'h1);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_state", 32'(dbg_rx_state), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk28);
    read_check("idle_all_rows", 8'h00);

    // A make/break
    press(8'h1C, 1'b0);
    read_check("a_make", 8'hFD);
    check("a_make_const", 32'(kd), 32'h1E);
    release_key(8'h1C, 1'b0);
    read_check("a_break", 8'hFD);

    // LShift + Z, then Backspace sharing Caps Shift
    press(8'h12, 1'b0);
    press(8'h1A, 1'b0);
    read_check("cs_z_row0", 8'hFE);
    check("cs_z_row0_const", 32'(kd), 32'h1C);
    read_check("cs_z_row7", 8'h7F);
    read_check("cs_z_ffmask", 8'hFF);
    release_key(8'h1A, 1'b0);
    press(8'h66, 1'b0);
    read_check("bs_rows0_4", 8'hEE);
    release_key(8'h66, 1'b0);
    read_check("bs_release_keeps_lshift", 8'hEE);
    release_key(8'h12, 1'b0);
    read_check("lshift_release", 8'hEE);

    // parity error
    f0 = ferr_cnt;
    send_byte(8'h1C, 1'b1);
    check("parity_err_pulses", 32'(ferr_cnt - f0), 32'd1);
    read_check("parity_err_no_key", 8'hFD);

    // timeout mid-frame
    f0 = ferr_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    repeat (1500) @(negedge clk28);
    check("timeout_pulses", 32'(ferr_cnt - f0), 32'd1);
    check("timeout_state_idle", 32'(dbg_rx_state), 32'h0);
    press(8'h1C, 1'b0);
    read_check("after_timeout_a", 8'hFD);
    release_key(8'h1C, 1'b0);

    // magic / reset keys
    press(8'h78, 1'b0);
    check("f11_make", 32'(n_magic), 32'h0);
    release_key(8'h78, 1'b0);
    check("f11_break", 32'(n_magic), 32'h1);
    press(8'h07, 1'b0);
    check("f12_make", 32'(n_kbrst), 32'h0);
    check("f12_magic_idle", 32'(n_magic), 32'h1);
    release_key(8'h07, 1'b0);
    check("f12_break", 32'(n_kbrst), 32'h1);

    // cursor up (E0 75)
    press(8'h75, 1'b1);
    read_check("arrow_up_make", 8'hEE);
    release_key(8'h75, 1'b1);
    read_check("arrow_up_break", 8'hEE);

    // randomized key traffic
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 9);
      code = plain_codes[$urandom_range(0, 39)];
      if (op < 6) begin
        if (held[code]) release_key(code, 1'b0); else press(code, 1'b0);
      end else if (op < 8) begin
        code = ext_junk[$urandom_range(0, 2)];
        if (held_ext[code]) release_key(code, 1'b1); else press(code, 1'b1);
      end else if (op == 8) begin
        code = unmapped[$urandom_range(0, 2)];
        if (held[code]) release_key(code, 1'b0); else press(code, 1'b0);
      end else if (!held[code]) begin
        // E1 after a prefix discards it, so the code lands as a plain make
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(code, 1'b0);
        held[code] = 1'b1;
      end
      read_check("rand_read", 8'($urandom_range(0, 255)));
    end

    // clock glitch shorter than the filter
    press(8'h1C, 1'b0);
    f0 = ferr_cnt;
    @(negedge clk28) ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk28);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk28);
    ps2_dat = 1'b1;
    check("glitch_state_idle", 32'(dbg_rx_state), 32'h0);
    check("glitch_no_err", 32'(ferr_cnt - f0), 32'd0);
    read_check("glitch_a_held", 8'hFD);

    // reset mid-frame
    press(8'h78, 1'b0);
    check("magic_before_reset", 32'(n_magic), 32'h0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(negedge clk28) rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk28);
    rst_n = 1'b1;
    check("midreset_state", 32'(dbg_rx_state), 32'h0);
    check("midreset_magic", 32'(n_magic), 32'h1);
    read_check("midreset_kd", 8'hFD);
    check("midreset_kd_const", 32'(kd), 32'h1F);
    read_check("midreset_all_rows", 8'h00);
    press(8'h1C, 1'b0);
    read_check("after_reset_a", 8'hFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
